// File: rtl/pwm_demod.sv
// Differential PWM capture: one signed sample (pos high-count minus neg high-count) per frame of 2^CW-1 clocks.
// Optional build macro PWM_DEMOD_AVG_EN averages each frame with the previous one.
module pwm_demod #(
  parameter int CW         = 8,
  parameter int SIL_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwm_pos,
  input  logic        pwm_neg,
  output logic [CW:0] sample,
  output logic        sample_valid,
  output logic        frame_err,
  output logic        silent
);

  localparam int SW = (SIL_FRAMES > 1) ? $clog2(SIL_FRAMES) : 1;
  localparam logic [CW-1:0] LAST     = {{(CW-1){1'b1}}, 1'b0};
  localparam logic [SW-1:0] SIL_LAST = SW'(SIL_FRAMES - 1);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t        state;
  logic          pos_m, pos_s, pos_d;
  logic          neg_m, neg_s, neg_d;
  logic [CW-1:0] fc, pcnt, ncnt;
  logic          err;
  logic [SW-1:0] sil;

  logic          inc_p, inc_n, both, rise, frame_quiet, err_nx, out_err;
  logic [CW-1:0] pcnt_nx, ncnt_nx;
  logic [CW:0]   frame_val, out_val;

`ifdef PWM_DEMOD_AVG_EN
  logic [CW:0]   prev_val;
  logic          prev_err;
  logic [CW+1:0] avg_sum;
`endif

  // Per-cycle contribution of the synced lines, and the value of a frame ending now.
  always_comb begin
    inc_p       = pos_s & ~neg_s;
    inc_n       = neg_s & ~pos_s;
    both        = pos_s & neg_s;
    rise        = (pos_s & ~pos_d) | (neg_s & ~neg_d);
    pcnt_nx     = pcnt + {{(CW-1){1'b0}}, inc_p};
    ncnt_nx     = ncnt + {{(CW-1){1'b0}}, inc_n};
    err_nx      = err | both;
    frame_val   = {1'b0, pcnt_nx} - {1'b0, ncnt_nx};
    frame_quiet = (pcnt_nx == {CW{1'b0}}) && (ncnt_nx == {CW{1'b0}});
`ifdef PWM_DEMOD_AVG_EN
    avg_sum     = {frame_val[CW], frame_val} + {prev_val[CW], prev_val};
    out_val     = avg_sum[CW+1:1];
    out_err     = err_nx | prev_err;
`else
    out_val     = frame_val;
    out_err     = err_nx;
`endif
  end

  // Synchronizers, frame state machine and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      {pos_m, pos_s, pos_d} <= 3'b000;
      {neg_m, neg_s, neg_d} <= 3'b000;
      fc           <= {CW{1'b0}};
      pcnt         <= {CW{1'b0}};
      ncnt         <= {CW{1'b0}};
      err          <= 1'b0;
      sil          <= {SW{1'b0}};
      sample       <= {(CW+1){1'b0}};
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      silent       <= 1'b1;
`ifdef PWM_DEMOD_AVG_EN
      prev_val     <= {(CW+1){1'b0}};
      prev_err     <= 1'b0;
`endif
    end else begin
      pos_m        <= pwm_pos;
      pos_s        <= pos_m;
      pos_d        <= pos_s;
      neg_m        <= pwm_neg;
      neg_s        <= neg_m;
      neg_d        <= neg_s;
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          // The edge cycle itself is frame cycle 0.
          if (rise) begin
            state  <= MEASURE;
            silent <= 1'b0;
            fc     <= CW'(1);
            pcnt   <= pcnt_nx;
            ncnt   <= ncnt_nx;
            err    <= both;
          end else begin
            silent <= 1'b1;
            fc     <= {CW{1'b0}};
            pcnt   <= {CW{1'b0}};
            ncnt   <= {CW{1'b0}};
            err    <= 1'b0;
          end
        end
        MEASURE: begin
          if (fc == LAST) begin
            sample_valid <= 1'b1;
            sample       <= out_val;
            frame_err    <= out_err;
            fc           <= {CW{1'b0}};
            pcnt         <= {CW{1'b0}};
            ncnt         <= {CW{1'b0}};
            err          <= 1'b0;
`ifdef PWM_DEMOD_AVG_EN
            prev_val     <= frame_val;
            prev_err     <= err_nx;
`endif
            if (frame_quiet && (sil == SIL_LAST)) begin
              state  <= IDLE;
              silent <= 1'b1;
              sil    <= {SW{1'b0}};
`ifdef PWM_DEMOD_AVG_EN
              prev_val <= {(CW+1){1'b0}};
              prev_err <= 1'b0;
`endif
            end else if (frame_quiet) begin
              sil <= sil + SW'(1);
            end else begin
              sil <= {SW{1'b0}};
            end
          end else begin
            fc   <= fc + CW'(1);
            pcnt <= pcnt_nx;
            ncnt <= ncnt_nx;
            err  <= err_nx;
          end
        end
        default: begin
          state  <= IDLE;
          silent <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_demod.sv
// Randomized scoreboard bench for pwm_demod; reference model scans the driven pin stream frame by frame.
module tb_pwm_demod;
  localparam int PERIOD = 255;
  localparam int SIL    = 4;
  localparam int LAT    = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pwm_pos = 1'b0;
  logic       pwm_neg = 1'b0;
  logic [8:0] sample;
  logic       sample_valid, frame_err, silent;

  typedef struct {int val; int err; int sil; int cyc;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  bit   pos_q[$];
  bit   neg_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   c0 = 0;

  pwm_demod dut (
    .clk(clk), .rst_n(rst_n), .pwm_pos(pwm_pos), .pwm_neg(pwm_neg),
    .sample(sample), .sample_valid(sample_valid), .frame_err(frame_err), .silent(silent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic push(input bit p, input bit n);
    pos_q.push_back(p);
    neg_q.push_back(n);
  endtask

  task automatic add_seg(input int typ, input int frames, input int duty);
    case (typ)
      0: for (int i = 0; i < frames * PERIOD; i++) push((i % PERIOD) < duty, 1'b0);
      1: for (int i = 0; i < frames * PERIOD; i++) push(1'b0, (i % PERIOD) < duty);
      2: for (int i = 0; i < frames * PERIOD; i++)
           push((i % PERIOD) < 50, ((i % PERIOD) >= 40) && ((i % PERIOD) < 60));
      3: for (int i = 0; i < frames * PERIOD; i++)
           push($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      4: for (int i = 0; i < duty; i++) push(1'b0, 1'b0);
      5: for (int i = 0; i < frames * PERIOD; i++) push(1'b1, 1'b0);
      default: push(1'b0, 1'b0);
    endcase
  endtask

  // Reference: find a rising edge, then cut back-to-back frames until SIL quiet frames in a row.
  task automatic model_stream();
    int  k = 0, start = 0, pc, nc, v, out, quiet = 0, prev_v = 0, len;
    bit  active = 0, er, prev_e = 0, pp, pn;
    exp_t e;
    len = pos_q.size();
    while (k < len) begin
      if (!active) begin
        pp = (k > 0) ? pos_q[k-1] : 1'b0;
        pn = (k > 0) ? neg_q[k-1] : 1'b0;
        if ((pos_q[k] && !pp) || (neg_q[k] && !pn)) begin
          active = 1;
          start  = k;
        end else begin
          k++;
          continue;
        end
      end
      if (start + PERIOD > len) break;
      pc = 0; nc = 0; er = 0;
      for (int i = start; i < start + PERIOD; i++) begin
        if (pos_q[i] && !neg_q[i]) pc++;
        if (neg_q[i] && !pos_q[i]) nc++;
        if (pos_q[i] && neg_q[i]) er = 1;
      end
      v = pc - nc;
`ifdef PWM_DEMOD_AVG_EN
      out   = (v + prev_v) >>> 1;
      e.err = int'(er | prev_e);
`else
      out   = v;
      e.err = int'(er);
`endif
      prev_v = v;
      prev_e = er;
      quiet  = (pc == 0 && nc == 0) ? quiet + 1 : 0;
      e.val  = out;
      e.cyc  = start + PERIOD - 1 + LAT;
      e.sil  = (quiet == SIL) ? 1 : 0;
      exp_q.push_back(e);
      k = start + PERIOD;
      if (quiet == SIL) begin
        active = 0; quiet = 0; prev_v = 0; prev_e = 0;
      end else begin
        start = k;
      end
    end
  endtask

  task automatic drive_stream();
    for (int k = 0; k < pos_q.size(); k++) begin
      @(negedge clk);
      if (k == 0) c0 = cyc;
      pwm_pos = pos_q[k];
      pwm_neg = neg_q[k];
    end
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
    check("drain", exp_q.size(), 0);
    pos_q.delete();
    neg_q.delete();
  endtask

  // Monitor: every sample_valid pulse pops one expected frame.
  always @(posedge clk) begin
    #1;
    if (rst_n && sample_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_valid: got sample %0d, expected no pulse (cycle %0d)", $signed(sample), cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("sample", int'($signed(sample)), mon_e.val);
        check("frame_err", int'(frame_err), mon_e.err);
        check("silent", int'(silent), mon_e.sil);
        check("valid_cycle", cyc - c0, mon_e.cyc);
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pwm_pos = ~pwm_pos;
      @(posedge clk);
      #1;
      check("rst_sample", int'(sample), 0);
      check("rst_valid", int'(sample_valid), 0);
      check("rst_silent", int'(silent), 1);
      check("rst_err", int'(frame_err), 0);
    end
    @(negedge clk);
    pwm_pos = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    add_seg(4, 0, 20);
    add_seg(0, 3, 100);
    add_seg(1, 2, 200);
    add_seg(5, 2, 0);
    add_seg(2, 1, 0);
    add_seg(0, 1, 0);
    add_seg(1, 1, 37);
    add_seg(4, 0, 6 * PERIOD);
    add_seg(1, 2, 120);
    for (int s = 0; s < 22; s++)
      add_seg($urandom_range(0, 5), $urandom_range(1, 3), $urandom_range(1, 6 * PERIOD));
    add_seg(4, 0, 5 * PERIOD + 10);
    model_stream();
    drive_stream();
    check("idle_silent", int'(silent), 1);

    for (int k = 0; k < 125; k++) begin
      @(negedge clk);
      pwm_pos = (k < 100);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_sample", int'(sample), 0);
    check("midrst_valid", int'(sample_valid), 0);
    check("midrst_silent", int'(silent), 1);
    check("midrst_err", int'(frame_err), 0);
    pwm_pos = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    add_seg(4, 0, 300);
    add_seg(0, 1, 100);
    add_seg(0, 1, 50);
    add_seg(0, 1, 100);
    add_seg(0, 1, 50);
    add_seg(4, 0, 5 * PERIOD + 10);
    model_stream();
    drive_stream();
    check("final_silent", int'(silent), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
